// File: rtl/fifo_flag_ctrl.sv
// fifo_flag_ctrl: gates FIFO read/write requests into pointer-counter
// enables, tracks occupancy and drives registered status flags plus
// sticky overflow / underflow / pointer-consistency errors.
module fifo_flag_ctrl #(
  parameter int FIFO_ADDRESS_SIZE = 3,
  parameter int AF_MARGIN         = 1,
  parameter int AE_MARGIN         = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_req,
  input  logic                         rd_req,
  input  logic                         err_clr,
  input  logic [FIFO_ADDRESS_SIZE:0]   w_ptr,
  input  logic [FIFO_ADDRESS_SIZE:0]   r_ptr,
  output logic                         cw_en,
  output logic                         cr_en,
  output logic [FIFO_ADDRESS_SIZE:0]   fill_count,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic                         overflow,
  output logic                         underflow,
  output logic                         ptr_err
);

  localparam int N     = FIFO_ADDRESS_SIZE;
  localparam int DEPTH = 1 << N;

  // Thresholds held one bit wider than fill_count so they match the
  // width of the next-occupancy sum.
  localparam logic [N+1:0] FULL_LVL = (N+2)'(DEPTH);
  localparam logic [N+1:0] AF_LVL   = (N+2)'(DEPTH - AF_MARGIN);
  localparam logic [N+1:0] AE_LVL   = (N+2)'(AE_MARGIN);

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } status_t;

  logic [N+1:0] next_cnt;
  logic [N:0]   ptr_diff;
  status_t      next_st;

  // Enables depend only on registered flags: a full FIFO still accepts a
  // read this cycle but never a write, and vice versa when empty.
  assign cw_en = wr_req & ~full;
  assign cr_en = rd_req & ~empty;

  // Pointer distance wraps naturally in N+1 bits.
  assign ptr_diff = w_ptr - r_ptr;

  // Next occupancy and the flags derived from it.
  always_comb begin
    next_cnt = {1'b0, fill_count}
             + {{(N+1){1'b0}}, cw_en}
             - {{(N+1){1'b0}}, cr_en};
    next_st.full         = (next_cnt == FULL_LVL);
    next_st.empty        = (next_cnt == '0);
    next_st.almost_full  = (next_cnt >= AF_LVL);
    next_st.almost_empty = (next_cnt <= AE_LVL);
  end

  // Occupancy counter and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_count   <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      fill_count   <= next_cnt[N:0];
      full         <= next_st.full;
      empty        <= next_st.empty;
      almost_full  <= next_st.almost_full;
      almost_empty <= next_st.almost_empty;
    end
  end

  // Sticky errors; a fresh set condition beats a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      ptr_err   <= 1'b0;
    end else begin
      overflow  <= (wr_req & full)  | (overflow  & ~err_clr);
      underflow <= (rd_req & empty) | (underflow & ~err_clr);
      ptr_err   <= (ptr_diff != fill_count) | (ptr_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_fifo_flag_ctrl.sv
// Directed bench for fifo_flag_ctrl: a reference model predicts each
// cycle's registered state, pushes it to a queue when stimulus is driven,
// and the entry is popped and compared after the clock edge.
module tb_fifo_flag_ctrl;

  localparam int N     = 3;
  localparam int DEPTH = 1 << N;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_req, rd_req, err_clr;
  logic [N:0]   w_ptr, r_ptr;
  logic         cw_en, cr_en;
  logic [N:0]   fill_count;
  logic         full, empty, almost_full, almost_empty;
  logic         overflow, underflow, ptr_err;

  fifo_flag_ctrl #(.FIFO_ADDRESS_SIZE(N), .AF_MARGIN(1), .AE_MARGIN(1)) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .rd_req(rd_req), .err_clr(err_clr),
    .w_ptr(w_ptr), .r_ptr(r_ptr), .cw_en(cw_en), .cr_en(cr_en),
    .fill_count(fill_count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow), .ptr_err(ptr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cnt;
    logic full, empty, af, ae, ovf, unf, perr;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // model state
  int   m_cnt;
  logic m_ovf, m_unf, m_perr;
  int   tb_w, tb_r;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_ovf = 0; m_unf = 0; m_perr = 0; tb_w = 0; tb_r = 0;
    w_ptr = '0; r_ptr = '0;
  endtask

  // One cycle: drive at posedge+1, check enables, predict, clock, compare.
  task automatic step(input logic wr, input logic rd, input logic clr,
                      input int off);
    logic m_full, m_empty, cw, cr;
    int   diff;
    exp_t e;
    wr_req = wr; rd_req = rd; err_clr = clr;
    w_ptr = (N+1)'(tb_w + off);
    r_ptr = (N+1)'(tb_r);
    #1;
    m_full  = (m_cnt == DEPTH);
    m_empty = (m_cnt == 0);
    cw = wr & ~m_full;
    cr = rd & ~m_empty;
    chk("cw_en", int'(cw_en), int'(cw));
    chk("cr_en", int'(cr_en), int'(cr));
    diff   = (tb_w + off - tb_r) & ((1 << (N+1)) - 1);
    m_ovf  = (wr & m_full)  | (m_ovf  & ~clr);
    m_unf  = (rd & m_empty) | (m_unf  & ~clr);
    m_perr = (diff != m_cnt) | (m_perr & ~clr);
    m_cnt  = m_cnt + int'(cw) - int'(cr);
    e.cnt = m_cnt;
    e.full = (m_cnt == DEPTH); e.empty = (m_cnt == 0);
    e.af = (m_cnt >= DEPTH - 1); e.ae = (m_cnt <= 1);
    e.ovf = m_ovf; e.unf = m_unf; e.perr = m_perr;
    q.push_back(e);
    @(posedge clk);
    #1;
    tb_w = (tb_w + int'(cw)) % (1 << (N+1));
    tb_r = (tb_r + int'(cr)) % (1 << (N+1));
    w_ptr = (N+1)'(tb_w);
    r_ptr = (N+1)'(tb_r);
    if (q.size() == 0) begin
      chk("queue_underrun", 1, 0);
    end else begin
      e = q.pop_front();
      chk("fill_count",   int'(fill_count),   e.cnt);
      chk("full",         int'(full),         int'(e.full));
      chk("empty",        int'(empty),        int'(e.empty));
      chk("almost_full",  int'(almost_full),  int'(e.af));
      chk("almost_empty", int'(almost_empty), int'(e.ae));
      chk("overflow",     int'(overflow),     int'(e.ovf));
      chk("underflow",    int'(underflow),    int'(e.unf));
      chk("ptr_err",      int'(ptr_err),      int'(e.perr));
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cnt"},   int'(fill_count),   0);
    chk({tag, "_empty"}, int'(empty),        1);
    chk({tag, "_ae"},    int'(almost_empty), 1);
    chk({tag, "_full"},  int'(full),         0);
    chk({tag, "_af"},    int'(almost_full),  0);
    chk({tag, "_ovf"},   int'(overflow),     0);
    chk({tag, "_unf"},   int'(underflow),    0);
    chk({tag, "_perr"},  int'(ptr_err),      0);
    chk({tag, "_cr_en"}, int'(cr_en),        0);
  endtask

  initial begin
    rst = 1'b1; wr_req = 0; rd_req = 1; err_clr = 0;
    model_reset();
    #12;
    chk_reset_outputs("por");
    @(posedge clk); #1;
    rd_req = 0; rst = 1'b0;

    // fill to 5, then async reset mid-cycle
    repeat (5) step(1, 0, 0, 0);
    chk("pre_rst_cnt", int'(fill_count), 5);
    wr_req = 0; rd_req = 1;
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("async");
    model_reset();
    @(posedge clk); #1;
    rd_req = 0; rst = 1'b0;
    step(0, 0, 0, 0);

    // fill: almost_full after 7th, full after 8th, 9th overflows
    repeat (8) step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);

    // simultaneous at full -> 7, refill
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);

    // drain 8, then underflow; clear alone, re-trigger, clear with rd
    repeat (8) step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    step(0, 0, 1, 0);

    // simultaneous at empty -> 1, up to 4, simultaneous at 4
    step(1, 1, 0, 0);
    repeat (3) step(1, 0, 0, 0);
    repeat (2) step(1, 1, 0, 0);

    // wrap: bursts of writes and reads so pointers pass 15 -> 0
    for (int i = 0; i < 40; i++) begin
      if ((i / 5) % 2 == 0) step(1, $urandom_range(0, 1), 0, 0);
      else                  step($urandom_range(0, 1), 1, 0, 0);
    end
    chk("wrap_ptr_err", int'(ptr_err), 0);

    // consistency: w_ptr one ahead for a single cycle
    step(0, 0, 0, 1);
    repeat (3) step(1, 1, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    if (q.size() != 0) chk("queue_leftover", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fifo_flag_ctrl.md
# fifo_flag_ctrl

FIFO status and enable controller that sits directly upstream of the read and write pointer counters. It gates raw read/write requests into the counter enables (`cr_en`, `cw_en`), tracks occupancy, and produces registered full/empty/almost flags plus sticky overflow, underflow and pointer-consistency error flags. It consumes the free-running extended pointers `r_ptr`/`w_ptr` only for a consistency check; occupancy is tracked by its own counter.

## Interface
- `FIFO_ADDRESS_SIZE`, 3, memory address width N; depth DEPTH = 2^N; pointers are N+1 bits.
- `AF_MARGIN`, 1, almost_full asserts when occupancy >= DEPTH-AF_MARGIN.
- `AE_MARGIN`, 1, almost_empty asserts when occupancy <= AE_MARGIN.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_req`  in  1  write request from producer.
- `rd_req`  in  1  read request from consumer.
- `err_clr`  in  1  synchronous clear of sticky error flags.
- `w_ptr`  in  N+1  write pointer from the write-address counter.
- `r_ptr`  in  N+1  read pointer from the read-address counter.
- `cw_en`  out  1  write counter/memory enable.
- `cr_en`  out  1  read counter enable.
- `fill_count`  out  N+1  registered occupancy, 0..DEPTH.
- `full`, `empty`, `almost_full`, `almost_empty`  out  1 each  registered status.
- `overflow`, `underflow`, `ptr_err`  out  1 each  sticky errors.

## Operation
- `cw_en = wr_req & ~full`; `cr_en = rd_req & ~empty`. Combinational from registered flags only; no same-cycle bypass.
- Consequences: read+write when full: read accepted, write rejected. Read+write when empty: write accepted, read rejected.
- Occupancy: `next = fill_count + cw_en - cr_en`, computed in N+2 bits, never outside 0..DEPTH by construction.
- Flags registered from `next`: full = (next==DEPTH); empty = (next==0); almost_full = (next >= DEPTH-AF_MARGIN); almost_empty = (next <= AE_MARGIN).
- overflow sets on `wr_req & full`; underflow sets on `rd_req & empty`.
- ptr_err sets when `(w_ptr - r_ptr) mod 2^(N+1) != fill_count`.
- All three error flags hold until `err_clr`. If `err_clr` and a new set condition coincide, set wins.
- Pointer wrap: subtraction is modulo 2^(N+1). A w_ptr wrap from 2^(N+1)-1 to 0 is not an error.
- Reset (async, any time, including mid-transfer): fill_count=0, empty=1, almost_empty=1, full=0, almost_full=0, all errors=0. cw_en/cr_en follow the reset flags immediately, so cr_en=0 during reset.
- The pointer counters share `rst` and must return to 0 together with this block.

## Timing
- Enable latency: 0 cycles. cw_en/cr_en are valid in the same cycle as the request.
- Flag/count latency: 1 cycle. The values after edge k reflect the enables sampled at edge k.
- Error latency: 1 cycle from the offending request or mismatch to the sticky flag.
- ptr_err is sampled every cycle outside reset, including the first cycle after reset release.
- Expected sustained rate: one write and one read per cycle when neither full nor empty.

## Test plan
- Reset: assert rst mid-cycle with fill_count=5 → all outputs at reset values immediately, with no clock edge required; after release, fill_count=0 and empty=1.
- Fill: 8 consecutive wr_req from empty (N=3) → fill_count 1..8; almost_full rises after the 7th write, full after the 8th. A 9th wr_req gives cw_en=0 and overflow=1 next cycle.
- Drain: 8 rd_req from full → almost_empty after count reaches 1, empty after the 8th read. A further rd_req gives cr_en=0 and underflow=1. err_clr alone clears it; err_clr coincident with another rd_req leaves underflow=1.
- Simultaneous: wr_req & rd_req at count 4 → count stays 4. At full: cr_en=1, cw_en=0, count becomes 7. At empty: cw_en=1, cr_en=0, count becomes 1.
- Wrap: 40 write/read cycles with interleaved bursts, pointers wrapping past 15→0 → ptr_err stays 0 and fill_count tracks a scoreboard.
- Consistency: force w_ptr one ahead of the true value for one cycle → ptr_err=1 next cycle and stays 1 until err_clr.
